acc_op_sequencer: RTL and testbench
===================================

# acc_op_sequencer

Multi-cycle controller that sequences the 8-bit accumulator logic datapath (LOAD/AND/OR/XOR/XNOR/NOT/CLR) of the RISC CPU. It accepts one operation at a time over a valid/ready handshake and fetches the memory operand over a request/acknowledge port when the opcode needs one. It then applies the logic function to the accumulator (AC) and signals completion. It sits between instruction decode and the memory interface and owns the AC register.

## Interface
- DATA_W, 8, accumulator and memory data width
- ADDR_W, 8, memory operand address width

- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  operation offered
- op_ready  out  1  sequencer can accept; high only in IDLE
- op_code  in  3  operation select, sampled at acceptance
- op_addr  in  ADDR_W  memory operand address, sampled at acceptance
- mem_req  out  1  memory read request, held until acknowledged
- mem_addr  out  ADDR_W  read address, stable while mem_req high
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  DATA_W  read data, sampled when mem_req && mem_ack
- ac  out  DATA_W  accumulator value
- done  out  1  one-cycle pulse; ac holds the result of the completed op
- busy  out  1  high in any state other than IDLE
- zero, parity  out  1 each  result flags (only with ACC_FLAGS_EN)

## Operation
- Opcodes: 000 LOAD (AC=M); 001 AND (AC&M); 010 OR (AC|M); 011 XOR (AC^M); 100 XNOR (~(AC^M)); 101 NOT (~AC); 110 CLR (AC=0); 111 NOP (AC unchanged).
- Opcodes 000–100 are memory ops. Opcodes 101–111 never assert mem_req.
- FSM states: IDLE, FETCH, EXEC.
  - IDLE: op_ready=1. On op_valid, latch op_code/op_addr. Go to FETCH for memory ops, otherwise to EXEC.
  - FETCH: mem_req=1 and mem_addr=latched address. On mem_ack, capture mem_rdata into the operand register and go to EXEC. Otherwise stay.
  - EXEC: AC <= f(AC, operand). done is registered high for the following cycle. Return to IDLE.
- All results are truncated to DATA_W. There is no carry.
- mem_ack outside FETCH is ignored. mem_rdata is captured only on the acknowledge edge.
- op_valid while op_ready=0 is ignored. The requester must hold op_valid until it sees the accept edge.
- A new op may be accepted in the same cycle that done is high, because the FSM is already in IDLE.

## Timing
- Reset values: ac=0, done=0, mem_req=0, mem_addr=0, busy=0, op_ready=1, zero=1, parity=0, state=IDLE.
- Reset asserted mid-operation aborts immediately and asynchronously. mem_req drops with no further handshake, and any in-flight ack is discarded.
- Non-memory op accepted at edge 0: EXEC in cycle 1, AC updated at edge 1, done=1 in cycle 2 with the new ac.
- Memory op accepted at edge 0: mem_req high from cycle 1. If mem_ack is sampled at edge k, then EXEC runs in cycle k+1 and done=1 in cycle k+2. The minimum latency is 3 cycles (ack in cycle 1).
- mem_req falls in the cycle after the ack edge.
- Back-to-back throughput: one non-memory op every 2 cycles.

## Configuration
- ACC_FLAGS_EN defined:
  - zero and parity ports exist and are registered together with ac.
  - zero = (result==0); parity = ^result (XOR reduction of the result).
  - Both flags hold when AC holds, including NOP.
- ACC_FLAGS_EN undefined: the ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package acc_pkg contains:
  - the opcode enum (OP_LOAD … OP_NOP);
  - the state enum (S_IDLE, S_FETCH, S_EXEC);
  - a function is_mem_op(op).
- One combinational sub-module, acc_logic_unit, computes f(op, ac, operand). All state stays in the top-level module.

## Test plan
- Reset, then LOAD addr 0x10 with ack in cycle 1 and rdata 0x95 -> mem_addr=0x10, done in cycle 3, ac=0x95.
- With ac=0x95, XNOR with M=0x8A and ack delayed 4 cycles -> mem_req held high for 4 cycles, done once, ac=0xE0.
- CLR then NOT back-to-back -> mem_req never asserted; ac=0x00 then 0xFF; done pulses 2 cycles apart.
- Stray mem_ack=1 with rdata=0x00 while in IDLE, then NOP -> ac unchanged; ack ignored.
- Assert rst while in FETCH -> mem_req=0, ac=0, op_ready=1 immediately. After release, the next op proceeds normally.
- With ACC_FLAGS_EN: AND 0xAA with 0x55 -> ac=0x00, zero=1, parity=0. Then OR with 0x07 -> ac=0x07, zero=0, parity=1.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types for the accumulator operation sequencer: opcodes, FSM states,
// and the memory-operand classification helper.
package acc_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_XNOR = 3'b100,
        OP_NOT  = 3'b101,
        OP_CLR  = 3'b110,
        OP_NOP  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_e;

    // Opcodes LOAD..XNOR take their second operand from memory.
    function automatic logic is_mem_op(input op_e op);
        return (op inside {OP_LOAD, OP_AND, OP_OR, OP_XOR, OP_XNOR});
    endfunction

endpackage

// File: rtl/acc_op_sequencer_if.sv
// Operation handshake, memory read port and accumulator status bundle.
// The zero/parity flag signals exist only when ACC_FLAGS_EN is defined.
interface acc_op_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_code;
    logic [ADDR_W-1:0] op_addr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] ac;
    logic              done;
    logic              busy;
`ifdef ACC_FLAGS_EN
    logic              zero;
    logic              parity;
`endif

    // Requester / memory side
    modport master (
        output op_valid, op_code, op_addr, mem_ack, mem_rdata,
`ifdef ACC_FLAGS_EN
        input  zero, parity,
`endif
        input  op_ready, mem_req, mem_addr, ac, done, busy
    );

    // Sequencer side
    modport slave (
        input  op_valid, op_code, op_addr, mem_ack, mem_rdata,
`ifdef ACC_FLAGS_EN
        output zero, parity,
`endif
        output op_ready, mem_req, mem_addr, ac, done, busy
    );

endinterface

// File: rtl/acc_logic_unit.sv
// Combinational logic function f(op, ac, operand) for the accumulator.
module acc_logic_unit
    import acc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] result
);

    // Select the logic function; NOP (and anything unexpected) keeps AC.
    always_comb begin
        result = ac;
        case (op)
            OP_LOAD: result = operand;
            OP_AND:  result = ac & operand;
            OP_OR:   result = ac | operand;
            OP_XOR:  result = ac ^ operand;
            OP_XNOR: result = ~(ac ^ operand);
            OP_NOT:  result = ~ac;
            OP_CLR:  result = '0;
            default: result = ac;
        endcase
    end

endmodule

// File: rtl/acc_op_sequencer.sv
// Accumulator operation sequencer: accepts one op over valid/ready, fetches a
// memory operand when needed, applies the logic function to AC and pulses done.
// Optional feature macro: ACC_FLAGS_EN adds registered zero/parity result flags.
module acc_op_sequencer
    import acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    acc_op_sequencer_if.slave  bus
);

    state_e            state;
    op_e               op_q;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] ac_q;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_req_q;
    logic              op_ready_q;
    logic              busy_q;
    logic              done_q;
    op_e               op_in;
`ifdef ACC_FLAGS_EN
    logic              zero_q;
    logic              parity_q;
`endif

    assign op_in = op_e'(bus.op_code);

    acc_logic_unit #(.DATA_W(DATA_W)) u_logic (
        .op      (op_q),
        .ac      (ac_q),
        .operand (operand_q),
        .result  (result)
    );

    // Sequencer FSM with registered handshake, status and accumulator outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= OP_NOP;
            op_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
            ac_q       <= '0;
`ifdef ACC_FLAGS_EN
            zero_q     <= 1'b1;
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        op_q       <= op_in;
                        op_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (is_mem_op(op_in)) begin
                            state      <= S_FETCH;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= bus.op_addr;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    ac_q       <= result;
`ifdef ACC_FLAGS_EN
                    zero_q     <= (result == '0);
                    parity_q   <= ^result;
`endif
                    done_q     <= 1'b1;
                    op_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    op_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    mem_req_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operand register: loaded only on the acknowledge edge of a fetch.
    always_ff @(posedge clk) begin
        if (state == S_FETCH && bus.mem_ack) begin
            operand_q <= bus.mem_rdata;
        end
    end

    assign bus.op_ready = op_ready_q;
    assign bus.busy     = busy_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.done     = done_q;
    assign bus.ac       = ac_q;
`ifdef ACC_FLAGS_EN
    assign bus.zero     = zero_q;
    assign bus.parity   = parity_q;
`endif

endmodule

// File: tb/tb_acc_op_sequencer.sv
// Self-checking bench for acc_op_sequencer: directed scenarios followed by
// randomized op sequences against a behavioural accumulator model.
// Flag checks are compiled in when ACC_FLAGS_EN is defined.
module tb_acc_op_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    acc_op_sequencer_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    acc_op_sequencer #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_ac = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference accumulator behaviour from the opcode table.
    function automatic logic [7:0] model_f(input logic [2:0] code, input logic [7:0] a, input logic [7:0] m);
        case (code)
            3'd0: return m;
            3'd1: return a & m;
            3'd2: return a | m;
            3'd3: return a ^ m;
            3'd4: return ~(a ^ m);
            3'd5: return ~a;
            3'd6: return 8'h00;
            default: return a;
        endcase
    endfunction

    task automatic check_ac(input string tag);
        check(tag, 32'(bus.ac), 32'(exp_ac));
`ifdef ACC_FLAGS_EN
        check({tag, "_zero"}, 32'(bus.zero), 32'(exp_ac == 8'h00));
        check({tag, "_parity"}, 32'(bus.parity), 32'(^exp_ac));
`endif
    endtask

    // Issue one op at a negedge with op_ready high; returns at the negedge of the done cycle.
    // dly = ack-free FETCH cycles before the ack cycle.
    task automatic do_op(input logic [2:0] code, input logic [7:0] addr, input logic [7:0] rdata, input int dly);
        bit mem;
        mem = (code <= 3'd4);
        check("op_ready_idle", 32'(bus.op_ready), 1);
        bus.op_valid  = 1'b1;
        bus.op_code   = code;
        bus.op_addr   = addr;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = 8'($urandom);
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op_code  = 3'($urandom);
        bus.op_addr  = 8'($urandom);
        bus.mem_ack  = 1'b0;
        check("busy", 32'(bus.busy), 1);
        check("op_ready_busy", 32'(bus.op_ready), 0);
        check("done_low", 32'(bus.done), 0);
        if (mem) begin
            for (int i = 0; i < dly; i++) begin
                check("mem_req_wait", 32'(bus.mem_req), 1);
                check("mem_addr", 32'(bus.mem_addr), 32'(addr));
                bus.mem_rdata = 8'($urandom);
                @(negedge clk);
                check("done_wait", 32'(bus.done), 0);
            end
            check("mem_req_ack", 32'(bus.mem_req), 1);
            check("mem_addr_ack", 32'(bus.mem_addr), 32'(addr));
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdata;
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'($urandom);
            check("mem_req_drop", 32'(bus.mem_req), 0);
            check("done_exec", 32'(bus.done), 0);
        end else begin
            check("mem_req_nonmem", 32'(bus.mem_req), 0);
        end
        @(negedge clk);
        exp_ac = model_f(code, exp_ac, rdata);
        check("done_pulse", 32'(bus.done), 1);
        check("busy_done", 32'(bus.busy), 0);
        check("mem_req_done", 32'(bus.mem_req), 0);
        check_ac("ac");
    endtask

    // Idle cycles with stray acknowledges that must be ignored.
    task automatic idle(input int n, input logic [7:0] stray);
        for (int i = 0; i < n; i++) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = stray;
            @(negedge clk);
            check("idle_done", 32'(bus.done), 0);
            check("idle_mem_req", 32'(bus.mem_req), 0);
            check("idle_ready", 32'(bus.op_ready), 1);
            check_ac("idle_ac");
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op_valid  = 1'b0;
        bus.op_code   = 3'd0;
        bus.op_addr   = 8'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_ac", 32'(bus.ac), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_ready", 32'(bus.op_ready), 1);
`ifdef ACC_FLAGS_EN
        check("rst_zero", 32'(bus.zero), 1);
        check("rst_parity", 32'(bus.parity), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // LOAD 0x95, then XNOR 0x8A with delayed ack
        do_op(3'd0, 8'h10, 8'h95, 0);
        check("load_ac", 32'(bus.ac), 'h95);
        do_op(3'd4, 8'h22, 8'h8A, 3);
        check("xnor_ac", 32'(bus.ac), 'hE0);

        // CLR then NOT back-to-back
        do_op(3'd6, 8'h00, 8'h00, 0);
        check("clr_ac", 32'(bus.ac), 'h00);
        do_op(3'd5, 8'h00, 8'h00, 0);
        check("not_ac", 32'(bus.ac), 'hFF);

        // stray ack in IDLE, then NOP
        idle(2, 8'h00);
        do_op(3'd7, 8'h00, 8'h00, 0);
        check("nop_ac", 32'(bus.ac), 'hFF);

        // reset asserted while in FETCH
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd1;
        bus.op_addr  = 8'h33;
        @(negedge clk);
        bus.op_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_mem_req", 32'(bus.mem_req), 1);
        #2;
        rst         = 1'b1;
        bus.mem_ack = 1'b1;
        #1;
        check("arst_mem_req", 32'(bus.mem_req), 0);
        check("arst_ac", 32'(bus.ac), 0);
        check("arst_ready", 32'(bus.op_ready), 1);
        check("arst_busy", 32'(bus.busy), 0);
        @(negedge clk);
        rst         = 1'b0;
        bus.mem_ack = 1'b0;
        exp_ac      = 8'h00;
        @(negedge clk);
        do_op(3'd0, 8'h44, 8'hAA, 1);

        // AND to zero, then OR to 0x07
        do_op(3'd1, 8'h45, 8'h55, 0);
        check("and_ac", 32'(bus.ac), 'h00);
        do_op(3'd2, 8'h46, 8'h07, 2);
        check("or_ac", 32'(bus.ac), 'h07);

        // randomized op stream
        for (int k = 0; k < 200; k++) begin
            do_op(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
